// File: rtl/sccb_target_if.sv
// rtl/sccb_target_if.sv - SCCB bus and register-file signals of the SCCB target
interface sccb_target_if;
  logic       scl;
  logic       sda_in;
  logic       sda_pull_low;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       nack_err;

  modport slave (
    input  scl, sda_in, rd_data,
    output sda_pull_low, wr_en, wr_addr, wr_data, rd_addr, busy, nack_err
  );

  modport master (
    output scl, sda_in, rd_data,
    input  sda_pull_low, wr_en, wr_addr, wr_data, rd_addr, busy, nack_err
  );
endinterface

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - oversampling SCCB/I2C target with write strobe and register-file reads
module sccb_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  sccb_target_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_in;
  logic [7:0] byte_in;
  logic [7:0] tx_shift;
  logic       ack_hold;
  logic       rw;
  logic       tx_acked;
  logic       wr_pend;
  logic       count_extra;

  // Idle-high bus: synchronizers reset to 1 so leaving reset never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in   = {shift_in[6:0], sda_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bit_cnt          <= 3'd0;
      shift_in         <= 8'h00;
      tx_shift         <= 8'h00;
      ack_hold         <= 1'b0;
      rw               <= 1'b0;
      tx_acked         <= 1'b0;
      wr_pend          <= 1'b0;
      count_extra      <= 1'b0;
      bus.sda_pull_low <= 1'b0;
      bus.wr_en        <= 1'b0;
      bus.wr_addr      <= 8'h00;
      bus.wr_data      <= 8'h00;
      bus.rd_addr      <= 8'h00;
      bus.busy         <= 1'b0;
      bus.nack_err     <= 1'b0;
    end else begin
      bus.wr_en    <= wr_pend;
      wr_pend      <= 1'b0;
      bus.nack_err <= 1'b0;
      if (start_det) begin
        state            <= ADDR;
        bit_cnt          <= 3'd7;
        bus.busy         <= 1'b1;
        bus.sda_pull_low <= 1'b0;
        ack_hold         <= 1'b0;
        tx_acked         <= 1'b0;
        count_extra      <= 1'b0;
      end else if (stop_det) begin
        state            <= IDLE;
        bus.sda_pull_low <= 1'b0;
        bus.busy         <= 1'b0;
        ack_hold         <= 1'b0;
        tx_acked         <= 1'b0;
        count_extra      <= 1'b0;
      end else begin
        // bit_cnt wraps 0 -> 7 on the 8th rise, so the next byte phase starts ready
        case (state)
          ADDR: if (scl_rise) begin
            shift_in <= byte_in;
            bit_cnt  <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              if (byte_in[7:1] == TARGET_ADDR) begin
                state <= ADDR_ACK;
                rw    <= byte_in[0];
              end else begin
                state        <= WAIT_STOP;
                bus.nack_err <= 1'b1;
              end
            end
          end
          REG: if (scl_rise) begin
            shift_in <= byte_in;
            bit_cnt  <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              bus.rd_addr <= byte_in;
              state       <= REG_ACK;
            end
          end
          DATA: if (scl_rise) begin
            shift_in <= byte_in;
            bit_cnt  <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              bus.wr_addr <= bus.rd_addr;
              bus.wr_data <= byte_in;
              wr_pend     <= 1'b1;
              state       <= DATA_ACK;
            end
          end
          // First fall after the 8th rise pulls SDA low, the next one releases it
          ADDR_ACK: if (scl_fall) begin
            ack_hold <= ~ack_hold;
            if (!ack_hold) begin
              bus.sda_pull_low <= 1'b1;
            end else if (rw) begin
              state            <= TX;
              tx_shift         <= bus.rd_data;
              bit_cnt          <= 3'd7;
              bus.sda_pull_low <= ~bus.rd_data[7];
            end else begin
              state            <= REG;
              bus.sda_pull_low <= 1'b0;
            end
          end
          REG_ACK: if (scl_fall) begin
            ack_hold         <= ~ack_hold;
            bus.sda_pull_low <= ~ack_hold;
            if (ack_hold) state <= DATA;
          end
          DATA_ACK: if (scl_fall) begin
            ack_hold         <= ~ack_hold;
            bus.sda_pull_low <= ~ack_hold;
            if (ack_hold) begin
              state       <= WAIT_STOP;
              count_extra <= 1'b1;
            end
          end
          TX: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              bus.sda_pull_low <= 1'b0;
              tx_acked         <= 1'b0;
              state            <= TX_ACK;
            end else begin
              bit_cnt          <= bit_cnt - 3'd1;
              tx_shift         <= {tx_shift[6:0], 1'b0};
              bus.sda_pull_low <= ~tx_shift[6];
            end
          end
          // Pointer advances at the ACK rise so rd_data has settled by the reload fall
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                tx_acked    <= 1'b1;
                bus.rd_addr <= bus.rd_addr + 8'd1;
              end else begin
                state <= WAIT_STOP;
              end
            end else if (scl_fall && tx_acked) begin
              tx_acked         <= 1'b0;
              state            <= TX;
              tx_shift         <= bus.rd_data;
              bit_cnt          <= 3'd7;
              bus.sda_pull_low <= ~bus.rd_data[7];
            end
          end
          WAIT_STOP: if (scl_rise && count_extra) begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              bus.nack_err <= 1'b1;
              count_extra  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB/I2C target (slave) that sits on the camera-config bus as the responder to our SCCB write master.
- Used as a synthesizable OV7670 register model for loopback bring-up and as an on-FPGA config sink.
- Oversamples SCL/SDA with the fast system clock and decodes START/STOP, address, register-address and data phases.
- Emits one write strobe per completed 3-phase write; serves 2-phase reads from an external register file.

Parameters:
- TARGET_ADDR, 7'h21, 7-bit device address (0x42 write / 0x43 read on the wire).
- SYNC_STAGES, 2, flip-flop synchronizer depth on SCL and SDA inputs (min 2).

Ports:
- clk  input  1  system clock, ≥16× SCL frequency (100 MHz nominal vs 400 kHz SCL).
- reset  input  1  asynchronous, active-high.
- scl  input  1  bus clock from master.
- sda_in  input  1  sampled SDA line (pad input).
- sda_pull_low  output  1  1 = drive SDA low; 0 = release (top level ties the pad to 1'bz when 0).
- wr_en  output  1  one-clk write strobe.
- wr_addr  output  8  register address for wr_en.
- wr_data  output  8  data for wr_en.
- rd_addr  output  8  current register pointer, presented to the register file.
- rd_data  input  8  register-file data at rd_addr; combinational, valid within 1 clk.
- busy  output  1  high from START until STOP or bus reset.
- nack_err  output  1  one-clk pulse when a transaction is abandoned (address mismatch or extra byte).

Behaviour:
- Reset values: sda_pull_low=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, nack_err=0, state=IDLE. All synchronizer flops reset to 1.
- Edge detection uses synchronized signals only, with one-cycle-delayed copies:
  - scl_rise / scl_fall: SCL edges.
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
- Bits are sampled on scl_rise. The target changes SDA only on scl_fall.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, TX, TX_ACK, WAIT_STOP.
- START in any state (including repeated START) → ADDR, bit_cnt=7, busy=1, sda_pull_low=0.
- STOP in any state → IDLE, sda_pull_low=0, busy=0. No write is issued for a partial byte.
- ADDR: shift 8 bits MSB first.
  - Upper 7 bits ≠ TARGET_ADDR → WAIT_STOP, nack_err pulse, SDA never driven.
  - Match → ADDR_ACK.
  - The R/W bit selects the path: R/W=0 → REG; R/W=1 → TX.
- ACK timing, all *_ACK states:
  - Assert sda_pull_low on the scl_fall following the 8th rise.
  - Hold through the 9th SCL high.
  - Release on the next scl_fall, then enter the next state.
- REG: 8 bits → latch rd_addr; REG_ACK → DATA.
- DATA: on the 8th scl_rise, set wr_addr=rd_addr and wr_data=byte; wr_en=1 exactly one clk later. Then DATA_ACK.
- After DATA_ACK: →WAIT_STOP. A further byte clocked in WAIT_STOP is not ACKed; nack_err pulses at its 8th rise.
- Read path (TX):
  - Load rd_data at entry.
  - Drive MSB on the scl_fall ending ADDR_ACK; each subsequent scl_fall shifts out the next bit.
  - For a 1 bit, sda_pull_low=0; for a 0 bit, sda_pull_low=1.
- TX_ACK: release SDA and sample the master bit at the 9th rise.
  - 0 (ACK) → rd_addr+1 with 8-bit wrap (0xFF→0x00), reload, TX.
  - 1 (NACK) → WAIT_STOP.
- The write path never increments rd_addr.
- Reset mid-transaction returns everything to reset values immediately. After reset, the first transaction is recognized only at the next START.
- SCL glitches shorter than SYNC_STAGES clk are not filtered beyond the synchronizer. Behaviour is defined only for clean SCL.

Test Plan:
- Master writes 0x42,0x12,0x80 + STOP → three ACK low pulses on SDA; a single wr_en with wr_addr=0x12, wr_data=0x80; busy falls after STOP.
- Master sends 0x60,0x12,0x80 → SDA never pulled low, nack_err once, no wr_en, busy=1 until STOP.
- Write phase 0x42,0x0A + STOP, then 0x43 with rd_data model reg[0x0A]=0x76 and master NACK → SDA bits 0111_0110 MSB first; rd_addr=0x0A; idle after STOP.
- Read 0x43 with master ACK after first byte, reg[0x0A]=0x76, reg[0x0B]=0x5C → two bytes 0x76, 0x5C; rd_addr ends at 0x0B.
- Write 0x42,0x3A then repeated START and 0x43 → read from 0x3A. STOP injected after 4 data bits → no wr_en.
- Assert reset during DATA bit 5 → sda_pull_low=0 and busy=0 within one clk. Next full write 0x42,0x01,0xFF → wr_en with 0x01/0xFF.
